// File: rtl/brs_pkg.sv
// ----------------------------------------------------------------------------
// brs_pkg
//
// Shared constants and types for the BRS operand path.
//
//   OPERAND_W        width of one operand byte on the input stream and on
//                    the op_a / op_b outputs
//   DEFAULT_TIMEOUT  default number of idle cycles a half-received pair
//                    (A byte captured, B byte still missing) is kept
//   operand_t        one operand byte
//   count_t          width of the idle counter and the pair counter
// ----------------------------------------------------------------------------
package brs_pkg;

    localparam int OPERAND_W       = 8;
    localparam int COUNT_W         = 8;
    localparam int DEFAULT_TIMEOUT = 255;

    typedef logic [OPERAND_W-1:0] operand_t;
    typedef logic [COUNT_W-1:0]   count_t;

endpackage : brs_pkg

// File: rtl/brs_operand_sequencer.sv
// ----------------------------------------------------------------------------
// brs_operand_sequencer
//
// Collects a byte stream of alternating A and B operands into (A, B) pairs
// and presents each pair to the downstream conditional XOR/AND unit through
// a valid/ready handshake. The A byte waits in a one-entry stage until its
// B byte arrives; the completed pair is then registered onto op_a/op_b with
// one cycle of latency. A stage left waiting too long is dropped and
// reported with a single-cycle timeout_err pulse. Operand data is passed
// through untouched.
//
// Parameters
//   TIMEOUT      idle cycles a half-received pair is held before it is
//                dropped
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   in_data      operand byte stream (A, B, A, B, ...)
//   in_valid     in_data is valid this cycle
//   in_ready     the block accepts in_data this cycle (combinational)
//   flush        discard any half-received pair
//   op_a         presented operand A (op_a[7] picks XOR/AND downstream)
//   op_b         presented operand B
//   op_valid     op_a/op_b hold a valid pair
//   op_ready     downstream consumes the pair this cycle
//   pair_count   number of pairs consumed downstream, modulo 256
//   timeout_err  one-cycle pulse when a half-received pair times out
// ----------------------------------------------------------------------------
module brs_operand_sequencer
    import brs_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OPERAND_W-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    output logic [OPERAND_W-1:0] op_a,
    output logic [OPERAND_W-1:0] op_b,
    output logic                 op_valid,
    input  logic                 op_ready,
    output logic [COUNT_W-1:0]   pair_count,
    output logic                 timeout_err
);

    // Idle counter compare value, sized to the counter itself.
    localparam count_t TIMEOUT_CNT = COUNT_W'(TIMEOUT);

    operand_t a_stage;
    logic     a_full;
    count_t   idle_cnt;

    logic     in_xfer;
    logic     out_xfer;
    logic     pair_done;
    logic     timeout_hit;

    // Handshake decode. A byte can always be taken while the stage is empty.
    // A B byte (stage full) needs somewhere to put the completed pair: the
    // output registers must be empty or be emptied by downstream this same
    // cycle. Flush blocks input so that a byte offered during a flush is not
    // silently lost.
    always_comb begin
        in_ready    = !flush && (!a_full || !op_valid || op_ready);
        in_xfer     = in_valid && in_ready;
        out_xfer    = op_valid && op_ready;
        pair_done   = in_xfer && a_full;
        timeout_hit = a_full && !in_xfer && !flush && (idle_cnt == TIMEOUT_CNT);
    end

    // Pair assembly, output register and counters.
    //
    // op_valid is set by a pair completion and otherwise cleared by an output
    // transfer; when both happen together the new pair replaces the consumed
    // one and op_valid stays high, which gives one pair per two input bytes.
    //
    // Flush only touches the half-received stage; a pair already presented
    // downstream stays put and can still be consumed during the flush.
    //
    // An input transfer clears the idle counter, so a B byte arriving in the
    // very cycle the counter hits TIMEOUT completes the pair instead of
    // timing out.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_stage     <= '0;
            a_full      <= 1'b0;
            idle_cnt    <= '0;
            op_a        <= '0;
            op_b        <= '0;
            op_valid    <= 1'b0;
            pair_count  <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;

            if (out_xfer) begin
                pair_count <= pair_count + COUNT_W'(1);
            end

            if (pair_done) begin
                op_a     <= a_stage;
                op_b     <= in_data;
                op_valid <= 1'b1;
            end else if (out_xfer) begin
                op_valid <= 1'b0;
            end

            if (flush) begin
                a_full   <= 1'b0;
                idle_cnt <= '0;
            end else if (in_xfer) begin
                idle_cnt <= '0;
                if (!a_full) begin
                    a_stage <= in_data;
                    a_full  <= 1'b1;
                end else begin
                    a_full  <= 1'b0;
                end
            end else if (a_full) begin
                if (timeout_hit) begin
                    a_full      <= 1'b0;
                    idle_cnt    <= '0;
                    timeout_err <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + COUNT_W'(1);
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end

endmodule : brs_operand_sequencer

// File: doc/brs_operand_sequencer.md
BRS_OPERAND_SEQUENCER -- requirements
Module: brs_operand_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, giving the maximum number of idle cycles a half-received pair is held.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous active-high reset, sampled on the clk rising edge.
REQ-004 The block SHALL have port in_data, input, 8 bits: the operand byte stream (A byte, then B byte, repeating).
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-007 The block SHALL have port flush, input, 1 bit: discard any half-received pair.
REQ-008 The block SHALL have port op_a, output, 8 bits: presented operand A to the downstream conditional XOR/AND unit (op_a[7] selects XOR=0 / AND=1 there).
REQ-009 The block SHALL have port op_b, output, 8 bits: presented operand B.
REQ-010 The block SHALL have port op_valid, output, 1 bit: the op_a/op_b pair is valid.
REQ-011 The block SHALL have port op_ready, input, 1 bit: downstream consumes the pair this cycle.
REQ-012 The block SHALL have port pair_count, output, 8 bits: number of pairs consumed downstream, modulo 256.
REQ-013 The block SHALL have port timeout_err, output, 1 bit: one-cycle pulse when a half-received pair is dropped by timeout.

Function
REQ-014 An input transfer SHALL occur exactly when in_valid && in_ready; an output transfer exactly when op_valid && op_ready.
REQ-015 Internal state SHALL be a_stage (8-bit), a_full (1-bit), the output registers op_a/op_b/op_valid, and idle_cnt (8-bit).
REQ-016 in_ready SHALL be combinational: !flush && (!a_full || !op_valid || op_ready).
REQ-017 An input transfer with a_full=0 SHALL load a_stage and set a_full=1.
REQ-018 An input transfer with a_full=1 SHALL load op_a<=a_stage and op_b<=in_data, set op_valid=1, and clear a_full, all in the same edge.
REQ-019 The latency from the B-byte transfer to op_valid=1 SHALL be one cycle.
REQ-020 op_a, op_b and op_valid SHALL hold stable while op_valid && !op_ready.
REQ-021 An output transfer without a simultaneous pair completion SHALL clear op_valid.
REQ-022 An output transfer coinciding with a pair completion SHALL leave op_valid=1 with the new pair, giving back-to-back throughput of one pair per two input bytes.
REQ-023 pair_count SHALL increment by 1 on every output transfer and wrap from 255 to 0.
REQ-024 When flush=1, the block SHALL clear a_full and idle_cnt; the presented pair and pair_count SHALL be unaffected.
REQ-025 idle_cnt SHALL reset to 0 on any input transfer or when a_full=0, and SHALL increment each cycle that a_full=1 with no input transfer.
REQ-026 When idle_cnt reaches TIMEOUT with a_full=1 and no input transfer, the block SHALL clear a_full and idle_cnt and pulse timeout_err high for exactly one cycle.
REQ-027 An input transfer in the same cycle as the timeout condition SHALL take priority, with no timeout_err.
REQ-028 op_a/op_b SHALL be passed unmodified; the block does no arithmetic on operand data.

Reset
REQ-029 When rst=1 at a clk edge, the block SHALL set a_full=0, op_valid=0, op_a=0, op_b=0, a_stage=0, idle_cnt=0, pair_count=0 and timeout_err=0.
REQ-030 Reset SHALL override all other inputs, including mid-pair and during a held output; any partial or presented pair is discarded.
REQ-031 in_ready SHALL be 1 in the first cycle after reset deasserts, provided flush=0.

Structure
REQ-032 The operand width constant (8) and the default TIMEOUT SHALL live in shared package brs_pkg.
REQ-033 The block SHALL be a single module with no sub-modules; its output feeds tt_um_BRS_3-style logic directly.

Verification
REQ-034 Bytes 0x0F, 0x33 with op_ready=1 SHALL produce op_a=0x0F, op_b=0x33, op_valid=1 one cycle after the 2nd byte, and pair_count=1 after consumption.
REQ-035 Six bytes streamed with op_ready=1 (0x81,0xFF,0x12,0x34,0x80,0x01) SHALL present three pairs with no gap cycles beyond the A-byte cycles, and pair_count=3.
REQ-036 With op_ready=0 and a pair held, a 3rd byte SHALL be accepted into a_stage, in_ready SHALL then be 0, the 4th byte SHALL stall, and the held op_a/op_b SHALL stay stable until op_ready=1.
REQ-037 With TIMEOUT=4 and A=0x55 followed by 5 idle cycles: timeout_err SHALL pulse once, and the next bytes 0xAA, 0x01 SHALL form the pair (0xAA, 0x01).
REQ-038 Flush asserted after byte 0x11 SHALL force in_ready=0 that cycle, and bytes 0x22, 0x33 SHALL then form the pair (0x22, 0x33).
REQ-039 rst asserted mid-pair with a pair held SHALL produce op_valid=0, pair_count=0 and op_a=op_b=0 on the next cycle.
